// File: rtl/seq_divider.sv
// Sequential restoring divider: unsigned DW-bit dividend by VW-bit divisor,
// one quotient bit per clock, with start/busy/done handshake.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic          div_zero,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] q;
  logic [VW:0]   r;
  logic [VW-1:0] d;
  logic [CW-1:0] count;

  logic [VW+1:0]        r_shift;
  logic signed [VW+1:0] trial;
  logic [VW:0]          r_nxt;
  logic [DW-1:0]        q_nxt;
  logic                 last_iter;

  // One restoring step: shift the next dividend bit into R and try to subtract D.
  always_comb begin
    r_shift   = {r, q[DW-1]};
    trial     = $signed(r_shift) - $signed({2'b00, d});
    r_nxt     = trial[VW+1] ? r_shift[VW:0] : trial[VW:0];
    q_nxt     = {q[DW-2:0], ~trial[VW+1]};
    last_iter = (count == CW'(DW - 1));
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (b == '0) ? DONE : CALC;
      CALC: if (last_iter) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= '0;
      r         <= '0;
      d         <= '0;
      count     <= '0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (b != '0) begin
              q        <= a;
              r        <= '0;
              d        <= b;
              count    <= '0;
              div_zero <= 1'b0;
            end else begin
              quotient  <= '1;
              remainder <= '0;
              div_zero  <= 1'b1;
            end
          end
        end
        CALC: begin
          q     <= q_nxt;
          r     <= r_nxt;
          count <= count + CW'(1);
          if (last_iter) begin
            quotient  <= q_nxt;
            remainder <= r_nxt[VW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule
